// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module  : dmem_arbiter_if
// Purpose : CPU, DMA and data-memory signal bundle for the dmem_arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_adr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_adr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_adr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_adr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_adr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Round-robin CPU/DMA arbiter and fixed-latency data-memory sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);
  localparam logic       c_own_cpu  = 1'b0;
  localparam logic       c_own_dma  = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_owner;
  logic          r_last_owner;
  logic          r_we;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          r_cpu_ack;
  logic          r_dma_ack;

  logic          w_eff_cpu;
  logic          w_eff_dma;
  logic          w_grant;
  logic          w_grant_owner;
  logic          w_done;
  logic          w_mem_read;
  logic          w_mem_write;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_owner = c_own_cpu;
    w_done        = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    // A requester is ignored during its own ack cycle so a held req is not re-served
    w_eff_cpu     = bus.cpu_req & ~r_cpu_ack;
    w_eff_dma     = bus.dma_req & ~r_dma_ack;

    case (r_state)
      S_IDLE: begin
        if (w_eff_cpu | w_eff_dma) begin
          w_grant       = 1'b1;
          w_grant_owner = (w_eff_cpu & w_eff_dma) ? ~r_last_owner : w_eff_dma;
          w_state_nxt   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_mem_read  = ~r_we;
        w_mem_write = r_we & (r_cnt == 4'd0);
        if (r_cnt == 4'd0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= c_own_cpu;
      r_last_owner <= c_own_dma;
      r_we         <= 1'b0;
      r_cnt        <= 4'd0;
      r_adr        <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;

      if (w_grant) begin
        r_owner <= w_grant_owner;
        r_we    <= w_grant_owner ? bus.dma_we    : bus.cpu_we;
        r_adr   <= w_grant_owner ? bus.dma_adr   : bus.cpu_adr;
        r_wdata <= w_grant_owner ? bus.dma_wdata : bus.cpu_wdata;
        r_cnt   <= c_cnt_init;
      end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_done) begin
        r_last_owner <= r_owner;
        if (r_owner == c_own_dma) begin
          r_dma_ack <= 1'b1;
          if (!r_we) r_dma_rdata <= bus.mem_rdata;
        end else begin
          r_cpu_ack <= 1'b1;
          if (!r_we) r_cpu_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  // Address/data stay on the bus after an access; only the strobes drop
  assign bus.mem_adr   = r_adr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.dma_ack   = r_dma_ack;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Purpose : Directed scoreboard bench for dmem_arbiter with a behavioural memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic preload = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word-indexed memory: combinational read, posedge write
  logic [31:0] mem [0:1023];
  always_comb bus.mem_rdata = mem[bus.mem_adr[11:2]];
  always @(posedge clk) begin
    if (preload) begin
      mem[250] <= 32'd8;   // 1000
      mem[251] <= 32'd2;   // 1004
      mem[252] <= 32'd3;   // 1008
    end else if (bus.mem_write) begin
      mem[bus.mem_adr[11:2]] <= bus.mem_wdata;
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          n_cpu_ack = 0;
  int          n_dma_ack = 0;
  int          n_wr = 0;
  time         t_last_wr = 0;
  bit          prev_cpu_ack = 1'b0;
  bit          prev_dma_ack = 1'b0;
  logic [31:0] q_cpu [$];
  logic [31:0] q_dma [$];
  bit          q_order [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop on every ack and compare who was served and what came back
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_write) begin
        n_wr++;
        t_last_wr = $time;
      end
      if (bus.cpu_ack || bus.dma_ack) begin
        check("ack_pending", q_order.size() != 0, 1'b1);
        if (q_order.size() != 0) check("grant_order", bus.dma_ack, q_order.pop_front());
      end
      if (bus.cpu_ack) begin
        n_cpu_ack++;
        check("cpu_ack_width", prev_cpu_ack, 1'b0);
        if (q_cpu.size() != 0) check("cpu_rdata", bus.cpu_rdata, q_cpu.pop_front());
      end
      if (bus.dma_ack) begin
        n_dma_ack++;
        check("dma_ack_width", prev_dma_ack, 1'b0);
        if (q_dma.size() != 0) check("dma_rdata", bus.dma_rdata, q_dma.pop_front());
      end
      prev_cpu_ack = bus.cpu_ack;
      prev_dma_ack = bus.dma_ack;
    end else begin
      prev_cpu_ack = 1'b0;
      prev_dma_ack = 1'b0;
    end
  end

  task automatic wait_ack(input bit who, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(who ? bus.dma_ack : bus.cpu_ack) && cyc < 30);
    check(who ? "dma_ack_timeout" : "cpu_ack_timeout", who ? bus.dma_ack : bus.cpu_ack, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int base;
    int done;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_adr = '0; bus.dma_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check("rst_cpu_ack",   bus.cpu_ack,   1'b0);
    check("rst_dma_ack",   bus.dma_ack,   1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_dma_rdata", bus.dma_rdata, 32'd0);
    check("rst_mem_read",  bus.mem_read,  1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_adr",   bus.mem_adr,   32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_stall", bus.cpu_stall, 1'b0);
    rst = 1'b1;

    // Single CPU read, cycle-accurate
    @(negedge clk);
    q_cpu.push_back(32'd2); q_order.push_back(1'b0);
    bus.cpu_adr = 32'd1004; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    #1 check("t1_stall_c0", bus.cpu_stall, 1'b1);
    @(negedge clk);
    check("t1_mem_read_c1", bus.mem_read, 1'b1);
    check("t1_mem_adr",     bus.mem_adr,  32'd1004);
    check("t1_stall_c1",    bus.cpu_stall, 1'b1);
    @(negedge clk);
    check("t1_mem_read_c2", bus.mem_read, 1'b1);
    check("t1_stall_c2",    bus.cpu_stall, 1'b1);
    @(negedge clk);
    check("t1_ack_c3",      bus.cpu_ack,  1'b1);
    check("t1_stall_c3",    bus.cpu_stall, 1'b0);
    check("t1_mem_read_c3", bus.mem_read, 1'b0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("t1_ack_c4",      bus.cpu_ack,  1'b0);

    // Both requesting out of reset: CPU first, DMA three cycles later
    rst = 1'b0;
    bus.cpu_adr = 32'd1000; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    bus.dma_adr = 32'd1008; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    q_cpu.push_back(32'd8); q_dma.push_back(32'd3);
    q_order.push_back(1'b0); q_order.push_back(1'b1);
    @(negedge clk);
    rst = 1'b1;
    wait_ack(1'b0, c);
    bus.cpu_req = 1'b0;
    wait_ack(1'b1, c);
    bus.dma_req = 1'b0;
    check("t2_dma_after_cpu", c, 3);

    // DMA write then CPU read-back
    base = n_wr;
    bus.dma_adr = 32'd1040; bus.dma_we = 1'b1; bus.dma_wdata = 32'hDEAD; bus.dma_req = 1'b1;
    q_dma.push_back(32'd3); q_order.push_back(1'b1);
    wait_ack(1'b1, c);
    bus.dma_req = 1'b0;
    check("t3_write_pulses",     n_wr - base, 1);
    check("t3_write_last_cycle", $time - t_last_wr, 10);
    check("t3_wdata_hold",       bus.mem_wdata, 32'hDEAD);
    bus.cpu_adr = 32'd1040; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    q_cpu.push_back(32'hDEAD); q_order.push_back(1'b0);
    wait_ack(1'b0, c);
    bus.cpu_req = 1'b0;
    check("t3_no_extra_write", n_wr - base, 1);

    // Reset mid-write: no write reaches memory, outputs clear without a clock
    @(negedge clk);
    bus.cpu_adr = 32'd1000; bus.cpu_we = 1'b1; bus.cpu_wdata = 32'h1234_5678; bus.cpu_req = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_async_mem_write", bus.mem_write, 1'b0);
    check("t5_async_mem_read",  bus.mem_read,  1'b0);
    check("t5_async_mem_adr",   bus.mem_adr,   32'd0);
    check("t5_async_mem_wdata", bus.mem_wdata, 32'd0);
    check("t5_async_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("t5_async_cpu_ack",   bus.cpu_ack,   1'b0);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_mem_unchanged", mem[250], 32'd8);

    // Six back-to-back contended reads alternate CPU, DMA, ...
    bus.cpu_adr = 32'd1000; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    bus.dma_adr = 32'd1004; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_cpu.push_back(32'd8); q_dma.push_back(32'd2);
      q_order.push_back(1'b0); q_order.push_back(1'b1);
    end
    rst = 1'b1;
    base = n_cpu_ack + n_dma_ack;
    done = 0;
    for (int i = 0; i < 60 && done == 0; i++) begin
      @(negedge clk);
      #1;
      if (n_cpu_ack + n_dma_ack - base >= 6) done = 1;
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    check("t4_six_acks", n_cpu_ack + n_dma_ack - base, 6);
    check("t4_drained",  q_order.size(), 0);
    repeat (4) @(negedge clk);
    check("t4_no_regrant", bus.mem_read, 1'b0);

    // DMA drops req after grant: access still completes, acked once
    bus.dma_adr = 32'd1008; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    q_dma.push_back(32'd3); q_order.push_back(1'b1);
    base = n_dma_ack;
    @(negedge clk);
    bus.dma_req = 1'b0;
    wait_ack(1'b1, c);
    check("t6_latency", c, 2);
    repeat (6) @(negedge clk);
    #1;
    check("t6_single_ack",  n_dma_ack - base, 1);
    check("t6_idle",        bus.mem_read, 1'b0);
    check("t6_dma_ack_low", bus.dma_ack,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
